// File: rtl/reco_uart_tx.sv
// Frame-driven UART reporter: emits "D<digit>:<4 hex>\r\n" as 8N1 when the recognised
// digit changes or every FRAME_DIV frames; at most one further packet waits while busy.
module reco_uart_tx #(
  parameter int CLK_FREQ  = 9_000_000,
  parameter int BAUD      = 115200,
  parameter int FRAME_DIV = 30
) (
  input  logic        TFT_VCLK,
  input  logic        rst_n,
  input  logic        TFT_VS_rise,
  input  logic [3:0]  reco_digital,
  input  logic [15:0] send_str,
  output logic        uart_txd,
  output logic        busy,
  output logic        pkt_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [7:0]    FRAME_LAST = 8'(FRAME_DIV - 1);
  localparam logic [3:0]    LAST_BYTE  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          r_state;
  logic [BW-1:0]   r_baud_cnt;
  logic [2:0]      r_bit_idx;
  logic [3:0]      r_byte_idx;
  logic [7:0]      r_frame_cnt;
  logic            r_pending;
  logic [3:0]      r_last_digit;
  logic [3:0]      r_snap_digit;
  logic [15:0]     r_snap_str;
  logic            r_txd;
  logic            r_busy;
  logic            r_pkt_done;

  logic            w_frame_wrap;
  logic            w_trigger;
  logic            w_baud_end;
  logic [7:0]      w_tx_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  assign w_frame_wrap = (r_frame_cnt == FRAME_LAST);
  assign w_trigger    = TFT_VS_rise && (w_frame_wrap || (reco_digital != r_last_digit));
  assign w_baud_end   = (r_baud_cnt == BAUD_LAST);

  // Packet bytes are built from the snapshot only, so live inputs cannot leak in mid-packet.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves w_tx_byte unassigned (no latch).
    w_tx_byte = 8'h0A;
    case (r_byte_idx)
      4'd0:    w_tx_byte = 8'h44;
      4'd1:    w_tx_byte = hex_char(r_snap_digit);
      4'd2:    w_tx_byte = 8'h3A;
      4'd3:    w_tx_byte = hex_char(r_snap_str[15:12]);
      4'd4:    w_tx_byte = hex_char(r_snap_str[11:8]);
      4'd5:    w_tx_byte = hex_char(r_snap_str[7:4]);
      4'd6:    w_tx_byte = hex_char(r_snap_str[3:0]);
      4'd7:    w_tx_byte = 8'h0D;
      default: w_tx_byte = 8'h0A;
    endcase
  end

  // Frame counter runs independently of the transmitter.
  always_ff @(posedge TFT_VCLK or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= 8'd0;
    end else if (TFT_VS_rise) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      r_frame_cnt <= w_frame_wrap ? 8'd0 : r_frame_cnt + 8'd1;
    end
  end

  always_ff @(posedge TFT_VCLK or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: snapshot and history registers are reset too, so an aborted packet leaves no trace.
      r_state      <= S_IDLE;
      r_baud_cnt   <= '0;
      r_bit_idx    <= 3'd0;
      r_byte_idx   <= 4'd0;
      r_pending    <= 1'b0;
      r_last_digit <= 4'd0;
      r_snap_digit <= 4'd0;
      r_snap_str   <= 16'd0;
      r_txd        <= 1'b1;
      r_busy       <= 1'b0;
      r_pkt_done   <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;

      if (r_state != S_IDLE) begin
        r_baud_cnt <= w_baud_end ? '0 : r_baud_cnt + BW'(1);
        if (w_trigger) r_pending <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_trigger || r_pending) begin
            r_snap_digit <= reco_digital;
            r_snap_str   <= send_str;
            r_last_digit <= reco_digital;
            r_pending    <= 1'b0;
            r_baud_cnt   <= '0;
            r_bit_idx    <= 3'd0;
            r_byte_idx   <= 4'd0;
            r_txd        <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_START;
          end
        end

        S_START: begin
          if (w_baud_end) begin
            r_bit_idx <= 3'd0;
            r_txd     <= w_tx_byte[0];
            r_state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_baud_end) begin
            if (r_bit_idx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= w_tx_byte[r_bit_idx + 3'd1];
            end
          end
        end

        S_STOP: begin
          if (w_baud_end) begin
            if (r_byte_idx == LAST_BYTE) begin
              // Line stays high here; a trigger or pending request restarts from IDLE.
              r_busy     <= 1'b0;
              r_pkt_done <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_byte_idx <= r_byte_idx + 4'd1;
              r_txd      <= 1'b0;
              r_state    <= S_START;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uart_txd = r_txd;
  assign busy     = r_busy;
  assign pkt_done = r_pkt_done;

endmodule

// File: tb/tb_reco_uart_tx.sv
// Bench for reco_uart_tx: a packet-level line model compared every cycle, a UART
// receiver decoding the line, and directed scenarios with hand-computed bytes.
`timescale 1ns/1ps
module tb_reco_uart_tx;

  localparam int CLK_FREQ  = 9_000_000;
  localparam int BAUD      = 115200;
  localparam int FRAME_DIV = 30;
  localparam int BD        = CLK_FREQ / BAUD;
  localparam int BYTE_CYC  = 10 * BD;
  localparam int PKT_CYC   = 9 * BYTE_CYC;
  localparam int VS_GAP    = 250;  // long enough that pulse 60 arrives after packet 1 ends

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        vs    = 1'b0;
  logic [3:0]  dig   = 4'd0;
  logic [15:0] str   = 16'd0;
  logic        txd, busy, done;

  reco_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FRAME_DIV(FRAME_DIV)) dut (
    .TFT_VCLK    (clk),
    .rst_n       (rst_n),
    .TFT_VS_rise (vs),
    .reco_digital(dig),
    .send_str    (str),
    .uart_txd    (txd),
    .busy        (busy),
    .pkt_done    (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- packet-level model ----------------
  string       hex_digits = "0123456789ABCDEF";
  int          m_frame = 0;
  logic [3:0]  m_last  = 4'd0;
  bit          m_pend  = 1'b0;
  bit          m_act   = 1'b0;
  bit          m_done  = 1'b0;
  int          m_t     = 0;
  logic [71:0] m_pkt   = '0;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return hex_digits[int'(n)];
  endfunction

  function automatic logic [71:0] build_pkt(input logic [3:0] d, input logic [15:0] s);
    return {8'h44, hex_char(d), 8'h3A, hex_char(s[15:12]), hex_char(s[11:8]),
            hex_char(s[7:4]), hex_char(s[3:0]), 8'h0D, 8'h0A};
  endfunction

  // Line level implied by the position within the packet: start, 8 data LSB first, stop.
  function automatic logic exp_line();
    int b, k;
    logic [7:0] byt;
    if (!m_act) return 1'b1;
    b   = m_t / BYTE_CYC;
    k   = (m_t % BYTE_CYC) / BD;
    byt = m_pkt[71 - 8*b -: 8];
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return byt[k-1];
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_frame = 0; m_last = 4'd0; m_pend = 1'b0; m_act = 1'b0;
      m_done  = 1'b0; m_t = 0; m_pkt = '0;
    end else begin : model_step
      bit trig;
      trig = vs && ((m_frame == FRAME_DIV - 1) || (dig != m_last));
      if (vs) m_frame = (m_frame + 1) % FRAME_DIV;
      m_done = 1'b0;
      if (m_act) begin
        if (trig) m_pend = 1'b1;
        m_t++;
        if (m_t == PKT_CYC) begin
          m_act  = 1'b0;
          m_done = 1'b1;
        end
      end else if (trig || m_pend) begin
        m_pkt  = build_pkt(dig, str);
        m_last = dig;
        m_pend = 1'b0;
        m_act  = 1'b1;
        m_t    = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check($sformatf("cycle %0d {txd,busy,pkt_done}", cyc),
          {29'd0, txd, busy, done}, {29'd0, exp_line(), m_act, m_done});
  end

  // ---------------- line receiver and activity monitor ----------------
  logic [7:0] rx_q[$];
  int         rx_frame_err = 0;

  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && txd === 1'b0) begin : rx_byte
      logic [9:0] bits;
      bit aborted;
      bits = '0;
      aborted = 1'b0;
      for (int c = 0; c <= BD/2 + 9*BD; c++) begin
        if (c > 0) @(negedge clk);
        if (rst_n !== 1'b1) aborted = 1'b1;
        if (c >= BD/2 && ((c - BD/2) % BD) == 0) bits[(c - BD/2) / BD] = txd;
      end
      if (!aborted) begin
        if (bits[0] == 1'b0 && bits[9] == 1'b1) rx_q.push_back(bits[8:1]);
        else rx_frame_err++;
      end
    end
  end

  int   start_q[$];
  int   done_q[$];
  int   busy_len = 0;
  int   last_busy_len = 0;
  logic prev_busy = 1'b0;

  initial forever begin
    @(negedge clk);
    if (busy && !prev_busy) begin
      start_q.push_back(cyc);
      busy_len = 0;
    end
    if (busy) busy_len++;
    if (!busy && prev_busy) last_busy_len = busy_len;
    if (done) done_q.push_back(cyc);
    prev_busy = busy;
  end

  // ---------------- helpers ----------------
  task automatic clear_logs();
    rx_q.delete();
    start_q.delete();
    done_q.delete();
  endtask

  task automatic pulse_vs(output int pc);
    @(posedge clk); #1 vs = 1'b1; pc = cyc;
    @(posedge clk); #1 vs = 1'b0;
  endtask

  task automatic wait_done(input string name, input int target, input int budget);
    int n = 0;
    while (done_q.size() < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, " pkt_done within budget"}, 32'(done_q.size() >= target), 32'd1);
  endtask

  task automatic check_pkt(input string tag, input int base, input logic [71:0] exp);
    for (int i = 0; i < 9; i++) begin
      logic [7:0] got;
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      check($sformatf("%s byte%0d", tag, i), {24'd0, got}, {24'd0, exp[71 - 8*i -: 8]});
    end
  endtask

  function automatic int start_delta(input int idx, input int ref_cyc);
    return (start_q.size() > idx) ? start_q[idx] - ref_cyc : -1;
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int pc, p30, p60;
    pc = 0; p30 = 0; p60 = 0;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset uart_txd", 32'(txd), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset pkt_done", 32'(done), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Digit-change trigger
    #1 dig = 4'd3; str = 16'h5311;
    @(posedge clk); #1 vs = 1'b1; pc = cyc;
    @(negedge clk); check("t1 line high in trigger cycle", 32'(txd), 32'd1);
    @(posedge clk); #1 vs = 1'b0;
    @(negedge clk); check("t1 line low one cycle later", 32'(txd), 32'd0);
    wait_done("t1", 1, PKT_CYC + 100);
    check("t1 start latency", start_delta(0, pc), 32'd1);
    check("t1 busy length", last_busy_len, 32'd7020);
    check_pkt("t1", 0, 72'h44_33_3A_35_33_31_31_0D_0A);
    repeat (200) @(posedge clk);
    check("t1 pkt_done pulse cycles", done_q.size(), 32'd1);
    check("t1 packets", start_q.size(), 32'd1);

    // Periodic trigger with a constant digit
    #1 dig = 4'd0; str = 16'h0000;
    apply_reset();
    for (int i = 1; i <= 60; i++) begin
      repeat (VS_GAP - 2) @(posedge clk);
      pulse_vs(pc);
      if (i == 30) p30 = pc;
      if (i == 60) p60 = pc;
    end
    wait_done("t2", 2, PKT_CYC + 100);
    repeat (200) @(posedge clk);
    check("t2 packets", start_q.size(), 32'd2);
    check("t2 first start after pulse 30", start_delta(0, p30), 32'd1);
    check("t2 second start after pulse 60", start_delta(1, p60), 32'd1);
    check_pkt("t2 pkt1", 0, 72'h44_30_3A_30_30_30_30_0D_0A);
    check_pkt("t2 pkt2", 9, 72'h44_30_3A_30_30_30_30_0D_0A);

    // Hex mapping of letters
    clear_logs();
    #1 dig = 4'hA; str = 16'hBEEF;
    pulse_vs(pc);
    wait_done("t3", 1, PKT_CYC + 100);
    check("t3 start latency", start_delta(0, pc), 32'd1);
    check_pkt("t3", 0, 72'h44_41_3A_42_45_45_46_0D_0A);
    repeat (100) @(posedge clk);

    // Pending path: only one extra packet however many triggers arrive while busy
    clear_logs();
    #1 dig = 4'd1; str = 16'h1234;
    pulse_vs(pc);
    repeat (98) @(posedge clk);
    #1 dig = 4'd2;
    pulse_vs(pc);
    for (int i = 0; i < 3; i++) begin
      repeat (500) @(posedge clk);
      pulse_vs(pc);
    end
    wait_done("t4", 2, 2 * PKT_CYC + 200);
    repeat (200) @(posedge clk);
    check("t4 packets", start_q.size(), 32'd2);
    check("t4 pkt_done pulses", done_q.size(), 32'd2);
    check("t4 second start after pkt_done",
          (done_q.size() > 0) ? start_delta(1, done_q[0]) : -1, 32'd1);
    check_pkt("t4 pkt1", 0, 72'h44_31_3A_31_32_33_34_0D_0A);
    check_pkt("t4 pkt2", 9, 72'h44_32_3A_31_32_33_34_0D_0A);

    // Snapshot stability: inputs change during byte 5
    clear_logs();
    #1 dig = 4'd7; str = 16'h9C0D;
    pulse_vs(pc);
    repeat (4 * BYTE_CYC + 300) @(posedge clk);
    #1 str = 16'hFFFF; dig = 4'd9;
    wait_done("t5", 1, PKT_CYC);
    check_pkt("t5", 0, 72'h44_37_3A_39_43_30_44_0D_0A);
    repeat (100) @(posedge clk);

    // Mid-packet reset during byte 4
    clear_logs();
    #1 dig = 4'd5; str = 16'h0A5F;
    pulse_vs(pc);
    repeat (3 * BYTE_CYC + 100) @(posedge clk);
    #2 check("t6 busy before reset", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("t6 line high in reset cycle", 32'(txd), 32'd1);
    check("t6 busy low in reset cycle", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
    repeat (2000) @(posedge clk);
    check("t6 no packet before new trigger", start_q.size(), 32'd0);
    check("t6 no bytes before new trigger", rx_q.size(), 32'd0);
    pulse_vs(pc);
    wait_done("t6", 1, PKT_CYC + 100);
    check("t6 start latency", start_delta(0, pc), 32'd1);
    check("t6 busy length", last_busy_len, 32'd7020);
    check_pkt("t6", 0, 72'h44_35_3A_30_41_35_46_0D_0A);
    repeat (100) @(posedge clk);

    check("rx framing errors", rx_frame_err, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
